// File: rtl/led_scan_driver.sv
// Round-robin 8-segment scanner: double-buffered digit codes, PWM brightness, dead time.
// Outputs registered one cycle after scan state; free-running, no backpressure.
module led_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_load,
  input  logic [BRIGHT_W-1:0]     i_bright,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic                    o_frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = CW + BRIGHT_W + 2;

  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [5*NUM_DIGITS-1:0] stage_digits;
  logic [5*NUM_DIGITS-1:0] disp_digits;
  logic [NUM_DIGITS-1:0]   stage_blank;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic                    pending;

  logic                    slot_end;
  logic                    frame_end;
  logic [4:0]              cur_code;
  logic                    cur_blank;
  logic [PW-1:0]           pwm_lhs;
  logic [PW-1:0]           pwm_rhs;
  logic                    lit;
  logic [7:0]              seg_hi;
  logic [NUM_DIGITS-1:0]   sel_hot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // The on-time comparison is done at full width so (i_bright+1)*SCAN_DIV cannot wrap.
  always_comb begin
    cur_code  = disp_digits[5*idx +: 5];
    cur_blank = disp_blank[idx];
    pwm_lhs   = PW'({cnt, {BRIGHT_W{1'b0}}});
    pwm_rhs   = (PW'(i_bright) + PW'(1)) * PW'(SCAN_DIV);
    lit       = (cnt != '0) && (pwm_lhs < pwm_rhs) && !cur_blank;
    seg_hi    = {cur_code[4], hex_to_seg(cur_code[3:0])};
    sel_hot   = NUM_DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Display copy only changes at the frame boundary so a frame never mixes old and new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_digits <= '0;
      stage_blank  <= '0;
      disp_digits  <= '0;
      disp_blank   <= '0;
      pending      <= 1'b0;
    end else begin
      if (i_load) begin
        stage_digits <= i_digits;
        stage_blank  <= i_blank;
      end
      if (frame_end && pending) begin
        disp_digits <= stage_digits;
        disp_blank  <= stage_blank;
      end
      if (i_load)
        pending <= 1'b1;
      else if (frame_end)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg <= SEG_OFF;
      o_sel <= SEL_OFF;
    end else if (lit) begin
      o_seg <= seg_hi ^ SEG_OFF;
      o_sel <= sel_hot ^ SEL_OFF;
    end else begin
      o_seg <= SEG_OFF;
      o_sel <= SEL_OFF;
    end
  end

endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Time-multiplexed driver for an N-digit, 8-segment (7 + decimal point) common-anode display.
- Holds one 5-bit code per digit: bit4 = decimal point, bits3:0 = hex value 0–F. Scans digits round-robin with per-digit blanking, global PWM brightness and inter-digit dead time.
- Sits between the application's display registers and the board pins. Replaces per-digit combinational decoders with a single registered scanner.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16).
- SCAN_DIV, 50000, clock cycles per digit slot (≥4).
- BRIGHT_W, 4, width of brightness control.
- SEG_ACTIVE_LOW, 1, 1 = o_seg bits low-active; 0 = high-active.
- SEL_ACTIVE_LOW, 1, 1 = o_sel bits low-active; 0 = high-active.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_digits  in  5*NUM_DIGITS  digit codes; digit k occupies bits [5k+4:5k]; digit 0 is rightmost.
- i_blank  in  NUM_DIGITS  1 = digit k dark regardless of code.
- i_load  in  1  single-cycle strobe: capture i_digits/i_blank into staging registers.
- i_bright  in  BRIGHT_W  on-time level, 0 = minimum, all-ones = full.
- o_seg  out  8  segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- o_sel  out  NUM_DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW.
- o_frame_done  out  1  one-cycle pulse when the last digit slot of a frame ends.

Behaviour:
- Reset (async, rst_n low):
  - o_seg and o_sel are at inactive level (all-ones when active-low); o_frame_done = 0.
  - Prescaler = 0, digit index = 0.
  - Staging and display registers cleared (codes 0, blank all 0), pending flag = 0.
  - The first slot after release is digit 0.
- Double buffering:
  - i_load high captures inputs into staging and sets pending.
  - Pending transfers staging into display registers only at frame boundary (prescaler = SCAN_DIV-1 and index = NUM_DIGITS-1), then clears.
  - i_load on the boundary cycle itself: new data is captured into staging and pending stays set; the transfer occurs at the next boundary.
  - Repeated loads within a frame: the last one wins.
- Prescaler: counts 0..SCAN_DIV-1, then wraps to 0. On wrap, index increments; at NUM_DIGITS-1 it wraps to 0.
- o_frame_done pulses on the cycle after the last digit slot of a frame ends. It is registered, aligned with the index returning to 0.
- Segment decode from bits3:0, high-active form:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - bit7 = code bit4 (decimal point).
  - Inverted when SEG_ACTIVE_LOW = 1.
- Enable window: the digit is lit only when all of the following hold:
  - prescaler ≠ 0 (one-cycle dead time at slot start, anti-ghosting);
  - prescaler*2^BRIGHT_W < (i_bright+1)*SCAN_DIV, with intermediate width sized to avoid overflow;
  - i_blank bit of the display copy is 0.
- Outside the enable window: o_sel = all inactive, o_seg = all inactive.
- Output timing:
  - o_seg and o_sel are registered, one cycle latency from prescaler/index state.
  - Exactly one o_sel bit is active at any time, or none.
- i_bright is sampled live; changes take effect within one cycle. It is not double-buffered.
- Full brightness: lit for prescaler 1..SCAN_DIV-1.
- Reset mid-frame: all outputs go inactive immediately; pending data is discarded.

Test Plan:
- Common bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2, both active-low.
1. Reset release, no load, bright=3 → o_sel cycles 1110,1101,1011,0111 with 7 lit cycles per 8-cycle slot; o_seg=C0 ("0") each slot; o_frame_done every 32 cycles.
2. Load i_digits={1F,0A,05,00} mid-frame → display unchanged until next o_frame_done. Then slots show C0, 92, 88, 0E (digit3 "F." with dp) in order.
3. i_blank=0010 → digit1 slot shows o_sel=1111 and o_seg=FF for all 8 cycles; other digits unaffected.
4. bright=0 → each slot lit only at prescaler 1 (1 cycle). bright=1 → lit prescaler 1..3.
5. Two loads in one frame (codes 3 then 7) → only 7 is displayed after boundary. A load asserted on the boundary cycle appears one frame later.
6. Assert rst_n low mid-slot of digit 2 → o_sel=1111, o_seg=FF asynchronously. After release, the scan restarts at digit 0 and the display shows zeros.
